// File: rtl/mesh_eoc_collector.sv
// Collects end-of-computation reports from a set of mesh tiles, captures their exit codes,
// and ends the run on completion, on an optional first failure, or on a watchdog expiry.
module mesh_eoc_collector #(
    parameter int N_TILES      = 4,
    parameter int CODE_W       = 8,
    parameter int TIMEOUT_W    = 32,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [N_TILES-1:0]          tile_mask_i,
    input  logic [TIMEOUT_W-1:0]        timeout_cycles_i,
    input  logic [N_TILES-1:0]          tile_eoc_valid_i,
    input  logic [N_TILES*CODE_W-1:0]   tile_eoc_code_i,
    output logic [N_TILES-1:0]          tile_eoc_ready_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [N_TILES*CODE_W-1:0]   exit_code_o,
    output logic [N_TILES-1:0]          done_mask_o,
    output logic                        fail_o,
    output logic [$clog2(N_TILES+1)-1:0] fail_count_o,
    output logic                        timeout_o
);

    localparam int CNT_W = $clog2(N_TILES+1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_reg, state_next;
    logic [N_TILES-1:0]     mask_reg;
    logic [TIMEOUT_W-1:0]   limit_reg;
    logic [TIMEOUT_W-1:0]   cnt_reg;
    logic [N_TILES-1:0]     done_mask_reg;
    logic                   fail_reg;
    logic [CNT_W-1:0]       fail_count_reg;
    logic                   timeout_reg;
    logic                   done_pulse_reg;
    logic [CODE_W-1:0]      code_reg [N_TILES];

    logic [N_TILES-1:0]     accept;
    logic [N_TILES-1:0]     nz;
    logic [N_TILES-1:0]     done_mask_next;
    logic [CNT_W-1:0]       nz_count;
    logic                   start_go;
    logic                   all_done;
    logic                   stop_hit;
    logic                   wd_hit;

    // Start is only honoured outside RUN; a mid-run start is silently dropped.
    assign start_go       = start_i && (state_reg != S_RUN);
    assign done_mask_next = done_mask_reg | accept;
    assign all_done       = (state_reg == S_RUN) && (done_mask_next == mask_reg);
    assign stop_hit       = (STOP_ON_FAIL != 0) && (|nz);
    assign wd_hit         = (state_reg == S_RUN) && (limit_reg != '0) &&
                            ((cnt_reg + TIMEOUT_W'(1)) == limit_reg);

    generate
        for (genvar gi = 0; gi < N_TILES; gi++) begin : g_tile
            assign accept[gi] = tile_eoc_ready_o[gi] & tile_eoc_valid_i[gi];
            assign nz[gi]     = accept[gi] && (tile_eoc_code_i[gi*CODE_W +: CODE_W] != '0);
            assign exit_code_o[gi*CODE_W +: CODE_W] = code_reg[gi];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)
                    code_reg[gi] <= '0;
                else if (start_go)
                    code_reg[gi] <= '0;
                else if (accept[gi])
                    code_reg[gi] <= tile_eoc_code_i[gi*CODE_W +: CODE_W];
            end
        end
    endgenerate

    always_comb begin
        nz_count = '0;
        for (int i = 0; i < N_TILES; i++)
            nz_count = nz_count + CNT_W'(nz[i]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start_i)
                    state_next = (tile_mask_i == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (all_done || stop_hit || wd_hit)
                    state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tile_eoc_ready_o = '0;
        busy_o           = 1'b0;
        if (state_reg == S_RUN) begin
            tile_eoc_ready_o = mask_reg & ~done_mask_reg;
            busy_o           = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_reg       <= '0;
            limit_reg      <= '0;
            cnt_reg        <= '0;
            done_mask_reg  <= '0;
            fail_reg       <= 1'b0;
            fail_count_reg <= '0;
            timeout_reg    <= 1'b0;
            done_pulse_reg <= 1'b0;
        end else begin
            // Pulse on every entry into DONE, including a zero-mask restart from DONE.
            done_pulse_reg <= (state_next == S_DONE) && ((state_reg == S_RUN) || start_go);
            if (start_go) begin
                mask_reg       <= tile_mask_i;
                limit_reg      <= timeout_cycles_i;
                cnt_reg        <= '0;
                done_mask_reg  <= '0;
                fail_reg       <= 1'b0;
                fail_count_reg <= '0;
                timeout_reg    <= 1'b0;
            end else if (state_reg == S_RUN) begin
                cnt_reg        <= cnt_reg + TIMEOUT_W'(1);
                done_mask_reg  <= done_mask_next;
                fail_count_reg <= fail_count_reg + nz_count;
                if (|nz)
                    fail_reg <= 1'b1;
                // Completion (or fail-stop) on the watchdog edge wins over the timeout.
                if (wd_hit && !all_done && !stop_hit)
                    timeout_reg <= 1'b1;
            end
        end
    end

    assign done_o       = done_pulse_reg;
    assign done_mask_o  = done_mask_reg;
    assign fail_o       = fail_reg;
    assign fail_count_o = fail_count_reg;
    assign timeout_o    = timeout_reg;

endmodule

// File: tb/tb_mesh_eoc_collector.sv
// Bench for mesh_eoc_collector: directed scenarios plus randomized runs checked against
// a schedule-level model that predicts the end cycle and captured results per run.
module tb_mesh_eoc_collector;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  tile_mask_i;
    logic [31:0] timeout_cycles_i;
    logic [3:0]  tile_eoc_valid_i;
    logic [31:0] tile_eoc_code_i;

    logic [3:0]  ready, s_ready;
    logic        busy, s_busy;
    logic        done, s_done;
    logic [31:0] exit_code, s_exit_code;
    logic [3:0]  done_mask, s_done_mask;
    logic        fail, s_fail;
    logic [2:0]  fail_count, s_fail_count;
    logic        timeout, s_timeout;

    int checks = 0;
    int errors = 0;

    int         sched [4];
    logic [7:0] code_tab [4];

    always #5 clk = ~clk;

    mesh_eoc_collector #(.N_TILES(4), .CODE_W(8), .TIMEOUT_W(32), .STOP_ON_FAIL(0)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .tile_mask_i(tile_mask_i),
        .timeout_cycles_i(timeout_cycles_i), .tile_eoc_valid_i(tile_eoc_valid_i),
        .tile_eoc_code_i(tile_eoc_code_i), .tile_eoc_ready_o(ready), .busy_o(busy),
        .done_o(done), .exit_code_o(exit_code), .done_mask_o(done_mask), .fail_o(fail),
        .fail_count_o(fail_count), .timeout_o(timeout));

    mesh_eoc_collector #(.N_TILES(4), .CODE_W(8), .TIMEOUT_W(32), .STOP_ON_FAIL(1)) dut_sof (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .tile_mask_i(tile_mask_i),
        .timeout_cycles_i(timeout_cycles_i), .tile_eoc_valid_i(tile_eoc_valid_i),
        .tile_eoc_code_i(tile_eoc_code_i), .tile_eoc_ready_o(s_ready), .busy_o(s_busy),
        .done_o(s_done), .exit_code_o(s_exit_code), .done_mask_o(s_done_mask), .fail_o(s_fail),
        .fail_count_o(s_fail_count), .timeout_o(s_timeout));

    // One full run: the model derives the ending run cycle from the report schedule and limit.
    task automatic do_run(input logic [3:0] m, input int t, input string nm);
        int         c, e;
        logic       exp_to;
        logic [3:0] exp_dm, done_before;
        logic [31:0] exp_code;
        logic [2:0] exp_fc;
        c = 0;
        for (int i = 0; i < 4; i++)
            if (m[i] && sched[i] > c) c = sched[i];
        exp_to = (t != 0) && (t - 1 < c);
        e      = exp_to ? t - 1 : c;
        exp_dm = '0; exp_code = '0; exp_fc = '0;
        for (int i = 0; i < 4; i++)
            if (m[i] && sched[i] <= e) begin
                exp_dm[i] = 1'b1;
                exp_code[i*8 +: 8] = code_tab[i];
                if (code_tab[i] != 8'h00) exp_fc = exp_fc + 3'd1;
            end
        @(negedge clk);
        start_i = 1'b1; tile_mask_i = m; timeout_cycles_i = t; tile_eoc_valid_i = '0;
        @(negedge clk);
        for (int k = 0; k <= e; k++) begin
            done_before = '0;
            for (int i = 0; i < 4; i++)
                if (m[i] && sched[i] < k) done_before[i] = 1'b1;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s run_busy k=%0d busy=%b done=%b want busy=1 done=0", nm, k, busy, done);
            end
            checks++;
            if (ready !== (m & ~done_before)) begin
                errors++;
                $display("FAIL %s ready k=%0d got=%b want=%b", nm, k, ready, m & ~done_before);
            end
            // Noise that must be ignored: start in RUN, new mask/limit, junk on done/unmasked tiles.
            start_i = 1'($urandom_range(0, 1));
            tile_mask_i = 4'($urandom);
            timeout_cycles_i = $urandom;
            for (int i = 0; i < 4; i++) begin
                tile_eoc_code_i[i*8 +: 8] = 8'($urandom);
                if (m[i] && sched[i] == k) begin
                    tile_eoc_valid_i[i] = 1'b1;
                    tile_eoc_code_i[i*8 +: 8] = code_tab[i];
                end else if (m[i] && sched[i] > k)
                    tile_eoc_valid_i[i] = 1'b0;
                else
                    tile_eoc_valid_i[i] = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ready !== 4'h0) begin
            errors++;
            $display("FAIL %s end_pulse done=%b busy=%b ready=%b want 1 0 0000", nm, done, busy, ready);
        end
        checks++;
        if (exit_code !== exp_code || done_mask !== exp_dm) begin
            errors++;
            $display("FAIL %s results code=%h mask=%b want code=%h mask=%b", nm, exit_code, done_mask, exp_code, exp_dm);
        end
        checks++;
        if (fail !== (exp_fc != 0) || fail_count !== exp_fc || timeout !== exp_to) begin
            errors++;
            $display("FAIL %s flags fail=%b cnt=%0d to=%b want fail=%b cnt=%0d to=%b",
                     nm, fail, fail_count, timeout, exp_fc != 0, exp_fc, exp_to);
        end
        tile_eoc_valid_i = 4'($urandom);
        tile_eoc_code_i = $urandom;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || exit_code !== exp_code || done_mask !== exp_dm || timeout !== exp_to) begin
            errors++;
            $display("FAIL %s hold done=%b code=%h mask=%b to=%b want 0 %h %b %b",
                     nm, done, exit_code, done_mask, timeout, exp_code, exp_dm, exp_to);
        end
        tile_eoc_valid_i = '0;
        $display("run %s mask=%b T=%0d end_cycle=%0d code=%h fails=%0d timeout=%b",
                 nm, m, t, e, exp_code, exp_fc, exp_to);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; tile_mask_i = '0; timeout_cycles_i = '0;
        tile_eoc_valid_i = '0; tile_eoc_code_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ready !== 4'h0 || exit_code !== 32'h0 ||
            done_mask !== 4'h0 || fail !== 1'b0 || fail_count !== 3'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b ready=%b code=%h mask=%b fail=%b cnt=%0d to=%b want all 0",
                     busy, done, ready, exit_code, done_mask, fail, fail_count, timeout);
        end
        rst_i = 1'b0;
        tile_eoc_valid_i = 4'hF;
        tile_eoc_code_i = 32'h11223344;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ready !== 4'h0 || done_mask !== 4'h0) begin
            errors++;
            $display("FAIL idle_wait busy=%b done=%b ready=%b mask=%b want 0 0 0000 0000", busy, done, ready, done_mask);
        end
        tile_eoc_valid_i = '0;
        $display("run reset idle");
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin sched[i] = i; code_tab[i] = 8'h00; end
        do_run(4'hF, 0, "sequential");
    endtask

    task automatic test_same_cycle();
        sched[0] = 1; sched[1] = 0; sched[2] = 0; sched[3] = 1;
        code_tab[0] = 8'h00; code_tab[1] = 8'h05; code_tab[2] = 8'h00; code_tab[3] = 8'h00;
        do_run(4'hF, 0, "same_cycle");
    endtask

    task automatic test_timeout();
        sched[0] = 0; sched[1] = 99; sched[2] = 99; sched[3] = 99;
        code_tab[0] = 8'h00; code_tab[1] = 8'h00; code_tab[2] = 8'h00; code_tab[3] = 8'h00;
        do_run(4'b0101, 10, "timeout");
    endtask

    task automatic test_tie();
        sched[0] = 3; sched[1] = 1; sched[2] = 0; sched[3] = 2;
        code_tab[0] = 8'h00; code_tab[1] = 8'h7E; code_tab[2] = 8'h00; code_tab[3] = 8'h01;
        do_run(4'hF, 4, "tie");
    endtask

    task automatic test_stop_on_fail();
        @(negedge clk);
        start_i = 1'b1; tile_mask_i = 4'hF; timeout_cycles_i = 0; tile_eoc_valid_i = '0;
        @(negedge clk);
        start_i = 1'b0;
        tile_eoc_valid_i = 4'b1000;
        tile_eoc_code_i = 32'hAB000000;
        @(negedge clk);
        checks++;
        if (s_done !== 1'b1 || s_busy !== 1'b0 || s_ready !== 4'h0 || s_exit_code !== 32'hAB000000) begin
            errors++;
            $display("FAIL sof_stop done=%b busy=%b ready=%b code=%h want 1 0 0000 ab000000",
                     s_done, s_busy, s_ready, s_exit_code);
        end
        checks++;
        if (s_fail !== 1'b1 || s_fail_count !== 3'd1 || s_done_mask !== 4'b1000 || s_timeout !== 1'b0) begin
            errors++;
            $display("FAIL sof_flags fail=%b cnt=%0d mask=%b to=%b want 1 1 1000 0",
                     s_fail, s_fail_count, s_done_mask, s_timeout);
        end
        checks++;
        if (busy !== 1'b1 || ready !== 4'b0111) begin
            errors++;
            $display("FAIL nosof_continue busy=%b ready=%b want 1 0111", busy, ready);
        end
        tile_eoc_valid_i = 4'b1111;
        tile_eoc_code_i = 32'h55000000;
        @(negedge clk);
        tile_eoc_valid_i = '0;
        checks++;
        if (done !== 1'b1 || exit_code !== 32'hAB000000 || fail_count !== 3'd1 || s_done_mask !== 4'b1000 ||
            s_exit_code !== 32'hAB000000) begin
            errors++;
            $display("FAIL sof_after done=%b code=%h cnt=%0d s_mask=%b s_code=%h want 1 ab000000 1 1000 ab000000",
                     done, exit_code, fail_count, s_done_mask, s_exit_code);
        end
        $display("run stop_on_fail tile3=ab");
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start_i = 1'b1; tile_mask_i = 4'hF; timeout_cycles_i = 0;
        @(negedge clk);
        start_i = 1'b0;
        tile_eoc_valid_i = 4'b0010;
        tile_eoc_code_i = 32'h00000300;
        @(negedge clk);
        tile_eoc_valid_i = '0;
        checks++;
        if (done_mask !== 4'b0010 || fail !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL prereset mask=%b fail=%b busy=%b want 0010 1 1", done_mask, fail, busy);
        end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ready !== 4'h0 || exit_code !== 32'h0 ||
            done_mask !== 4'h0 || fail !== 1'b0 || fail_count !== 3'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL async_reset busy=%b done=%b ready=%b code=%h mask=%b fail=%b cnt=%0d to=%b want all 0",
                     busy, done, ready, exit_code, done_mask, fail, fail_count, timeout);
        end
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1; tile_mask_i = 4'h0; timeout_cycles_i = 5;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || exit_code !== 32'h0 || done_mask !== 4'h0 ||
            fail !== 1'b0 || fail_count !== 3'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL zero_mask done=%b busy=%b code=%h mask=%b fail=%b cnt=%0d to=%b want 1 then 0s",
                     done, busy, exit_code, done_mask, fail, fail_count, timeout);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_mask_pulse done=%b want 0", done);
        end
        $display("run reset_mid_run then zero mask");
    endtask

    task automatic test_random();
        logic [3:0] m;
        int         t;
        for (int n = 0; n < 40; n++) begin
            m = 4'($urandom_range(1, 15));
            t = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 9));
            for (int i = 0; i < 4; i++) begin
                sched[i]    = int'($urandom_range(0, 7));
                code_tab[i] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            do_run(m, t, "random");
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_same_cycle();
        test_timeout();
        test_tie();
        test_stop_on_fail();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
